mouse_event_queue: RTL and testbench

Buffers mouse state changes for the CPU. The block sits directly downstream of the PS/2 mouse receiver and consumes its 28-bit status word `{run, btns, 2'b0, y, 2'b0, x}`. Each change of position or buttons while the receiver is running becomes a queued event. Consecutive pure-motion events are optionally coalesced, and the CPU drains the queue through a single read-and-pop data word plus a level interrupt.

---
 rtl/mouse_event_queue.sv | 125 ++++++++++++
 tb/tb_mouse_event_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_event_queue.sv
// mouse_event_queue: turns PS/2 receiver status changes into queued events
// that the CPU drains through a read-and-pop data word and a level interrupt.
module mouse_event_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter bit          COALESCE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] mouse,
    input  logic        rd,
    output logic [31:0] dout,
    output logic        irq
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [2:0] btns;
        logic [9:0] y;
        logic [9:0] x;
    } entry_t;

    typedef struct packed {
        logic   run;
        entry_t e;
    } sample_t;

    sample_t       m_q;
    sample_t       m_p;
    entry_t        mem [DEPTH];
    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    logic [CW-1:0] count;
    logic          ovf;

    logic          rise;
    logic          evt;
    logic          pop;
    logic          tail_safe;
    logic          coal;
    logic          push_ok;
    logic          drop;
    logic          wr_en;
    logic [PW-1:0] tail_addr;
    logic [PW-1:0] wr_addr;
    entry_t        tail;
    entry_t        head;
    sample_t       m_in;

    // Padding bits of the receiver word carry no information.
    logic unused_pad;
    assign unused_pad = ^{mouse[23:22], mouse[11:10]};

    assign m_in = '{run: mouse[27],
                    e:   '{btns: mouse[26:24], y: mouse[21:12], x: mouse[9:0]}};

    // Event detection and queue write/pop decisions for this cycle.
    always_comb begin
        rise      = 1'b0;
        evt       = 1'b0;
        pop       = 1'b0;
        tail_safe = 1'b0;
        coal      = 1'b0;
        push_ok   = 1'b0;
        drop      = 1'b0;
        tail_addr = wp - PW'(1);
        tail      = mem[tail_addr];
        rise      = m_q.run & ~m_p.run;
        evt       = rise | (m_q.run & m_p.run & (m_q.e != m_p.e));
        pop       = rd & (count != '0);
        // The tail survives this cycle unless it is the only entry and is being read.
        tail_safe = (count >= CW'(2)) | ((count == CW'(1)) & ~rd);
        coal      = COALESCE & evt & ~rise & tail_safe & (tail.btns == m_q.e.btns);
        push_ok   = evt & ~coal & ((count < CW'(DEPTH)) | pop);
        drop      = evt & ~coal & ~push_ok;
        wr_en     = coal | push_ok;
        wr_addr   = coal ? tail_addr : wp;
    end

    // Input capture, pointers, occupancy and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= '0;
            m_p   <= '0;
            rp    <= '0;
            wp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            m_p <= m_q;
            m_q <= m_in;
            if (pop) begin
                rp <= rp + PW'(1);
            end
            if (push_ok) begin
                wp <= wp + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop);
            if (rd) begin
                ovf <= 1'b0;
            end else if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Entry storage; reset suppresses the write so an in-flight event is lost.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_addr] <= m_q.e;
        end
    end

    // CPU-visible head word and interrupt level.
    always_comb begin
        head = mem[rp];
        dout = {(count != '0), ovf, 2'b00, count, 24'd0};
        if (count != '0) begin
            dout[23:0] = {head.btns, 1'b0, head.y, head.x};
        end
        irq = (count != '0);
    end

endmodule

// File: tb/tb_mouse_event_queue.sv
// tb_mouse_event_queue: drives two queue configurations with shared stimulus
// and compares every cycle's head word against a queue-based reference.
module tb_mouse_event_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd  = 1'b0;
    logic [27:0] mouse = '0;
    logic [31:0] dout_c;
    logic [31:0] dout_n;
    logic        irq_c;
    logic        irq_n;

    int errors = 0;
    int checks = 0;

    // Reference state: entry queues, overflow flags, last two receiver samples.
    logic [22:0] q_c [$];
    logic [22:0] q_n [$];
    logic        ov_c = 1'b0;
    logic        ov_n = 1'b0;
    logic [27:0] hq = '0;
    logic [27:0] hp = '0;
    logic [32:0] sb_c [$];
    logic [32:0] sb_n [$];
    logic [27:0] cur;

    mouse_event_queue #(.DEPTH(8), .COALESCE(1'b1)) dut_c (
        .clk(clk), .rst(rst), .mouse(mouse), .rd(rd), .dout(dout_c), .irq(irq_c)
    );

    mouse_event_queue #(.DEPTH(8), .COALESCE(1'b0)) dut_n (
        .clk(clk), .rst(rst), .mouse(mouse), .rd(rd), .dout(dout_n), .irq(irq_n)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] mk(input logic run, input logic [2:0] b,
                                       input logic [9:0] y, input logic [9:0] x);
        return {run, b, 2'b00, y, 2'b00, x};
    endfunction

    // Expected {irq, dout} for a given queue content and overflow flag.
    function automatic logic [32:0] expect_word(input logic [22:0] q [$], input logic ov);
        logic [32:0] w;
        int n;
        n = q.size();
        if (n == 0) begin
            w = {1'b0, 1'b0, ov, 2'b00, 4'd0, 24'd0};
        end else begin
            w = {1'b1, 1'b1, ov, 2'b00, 4'(n), q[0][22:20], 1'b0, q[0][19:0]};
        end
        return w;
    endfunction

    // One clock of the reference queue for the current rd/rst and sample history.
    task automatic model_step(inout logic [22:0] q [$], inout logic ov,
                              input int depth, input bit coal_en);
        logic [22:0] ce;
        logic [22:0] pe;
        bit rise;
        bit evt;
        bit pop;
        bit coal;
        int n;
        if (rst) begin
            q.delete();
            ov = 1'b0;
            return;
        end
        ce   = {hq[26:24], hq[21:12], hq[9:0]};
        pe   = {hp[26:24], hp[21:12], hp[9:0]};
        rise = hq[27] && !hp[27];
        evt  = rise || (hq[27] && hp[27] && ce != pe);
        n    = q.size();
        pop  = rd && n > 0;
        coal = 1'b0;
        if (coal_en && evt && !rise && n > 0) begin
            if ((n >= 2 || !rd) && q[n-1][22:20] == ce[22:20]) coal = 1'b1;
        end
        if (coal) q[n-1] = ce;
        if (pop) void'(q.pop_front());
        if (evt && !coal) begin
            if (n < depth || pop) q.push_back(ce);
            else ov = 1'b1;
        end
        if (rd) ov = 1'b0;
    endtask

    // Apply one cycle of stimulus and queue the expected post-edge outputs.
    task automatic cyc(input logic [27:0] m, input logic r, input logic rs);
        @(negedge clk);
        mouse = m;
        rd    = r;
        rst   = rs;
        model_step(q_c, ov_c, 8, 1'b1);
        model_step(q_n, ov_n, 8, 1'b0);
        if (rs) begin
            hq = '0;
            hp = '0;
        end else begin
            hp = hq;
            hq = m;
        end
        sb_c.push_back(expect_word(q_c, ov_c));
        sb_n.push_back(expect_word(q_n, ov_n));
    endtask

    task automatic hold(input int cycles, input logic r);
        for (int i = 0; i < cycles; i++) cyc(cur, r, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented head word and interrupt after each edge.
    initial begin
        logic [32:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_c.size() > 0) begin
                e = sb_c.pop_front();
                check("dout_coal", dout_c, e[31:0]);
                check("irq_coal", 32'(irq_c), 32'(e[32]));
            end
            if (sb_n.size() > 0) begin
                e = sb_n.pop_front();
                check("dout_nocoal", dout_n, e[31:0]);
                check("irq_nocoal", 32'(irq_n), 32'(e[32]));
            end
        end
    end

    initial begin
        cur = '0;
        // Reset, then first running sample.
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        cur = mk(1'b1, 3'd4, 10'd5, 10'd7);
        hold(3, 1'b0);
        // Pure-motion changes: merged in one config, queued in the other.
        for (int i = 8; i <= 10; i++) begin
            cur = mk(1'b1, 3'd4, 10'd5, 10'(i));
            cyc(cur, 1'b0, 1'b0);
        end
        hold(2, 1'b0);
        // Button change then two pops.
        cur = mk(1'b1, 3'd0, 10'd5, 10'd10);
        hold(3, 1'b0);
        hold(1, 1'b1);
        hold(1, 1'b1);
        hold(8, 1'b1);
        // Overflow: nine distinct events, no reads, then read back.
        for (int i = 1; i <= 9; i++) begin
            cur = mk(1'b1, 3'(i), 10'(200 + i), 10'(100 + i));
            cyc(cur, 1'b0, 1'b0);
        end
        hold(3, 1'b0);
        hold(3, 1'b1);
        // Refill to full, then event pushed while reading.
        for (int i = 2; i <= 6; i++) begin
            cur = mk(1'b1, 3'(i), 10'(300 + i), 10'(i));
            cyc(cur, 1'b0, 1'b0);
        end
        hold(2, 1'b0);
        cur = mk(1'b1, 3'd7, 10'd999, 10'd1);
        cyc(cur, 1'b0, 1'b0);
        hold(1, 1'b1);
        hold(2, 1'b0);
        // Drain past empty; reads at empty must not disturb the pointers.
        hold(12, 1'b1);
        hold(2, 1'b0);
        // Five entries, an in-flight change, then reset with run held.
        for (int i = 1; i <= 5; i++) begin
            cur = mk(1'b1, 3'(i), 10'(i), 10'(50 + i));
            cyc(cur, 1'b0, 1'b0);
        end
        hold(2, 1'b0);
        cur = mk(1'b1, 3'd0, 10'd1, 10'd1);
        cyc(cur, 1'b0, 1'b0);
        cyc(cur, 1'b0, 1'b1);
        hold(5, 1'b0);
        hold(1, 1'b1);
        hold(2, 1'b0);
        // Randomised traffic with varying read pressure.
        for (int k = 0; k < 1600; k++) begin
            logic r;
            logic rs;
            if ($urandom_range(2) == 0) begin
                case ($urandom_range(7))
                    0, 1, 2: cur[9:0]   = 10'($urandom);
                    3, 4:    cur[21:12] = 10'($urandom);
                    5:       cur[26:24] = 3'($urandom);
                    6:       cur = mk(1'b1, 3'($urandom), 10'($urandom), 10'($urandom));
                    default: cur[27]    = ($urandom_range(3) != 0) ? 1'b1 : ~cur[27];
                endcase
            end
            r  = (k < 800) ? ($urandom_range(4) == 0) : ($urandom_range(1) == 0);
            rs = ($urandom_range(299) == 0);
            cyc(cur, r, rs);
        end
        hold(3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_c.size() != 0 || sb_n.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left %0d/%0d expected 0", sb_c.size(), sb_n.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
